// File: rtl/spi_reg_sequencer.sv
// Register-access front end: packs host read/write commands into one SPI
// frame, sequences chip select, and returns one {err, rw, rdata} reply.
// Ports: CLK, nRST (sync, active-low)
//   cmd_enq_*  host command in, {rw, addr, wdata}
//   spi_req_*  frame to the shift engine; spi_rsp_* frame back from it
//   rsp_enq_*  reply to host {err, rw, rdata}; cs_n chip select; busy.
module spi_reg_sequencer #(
  parameter int WIDTH    = 26,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int CS_SETUP = 1,
  parameter int CS_GAP   = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    cmd_enq_ena,
  output logic                    cmd_enq_rdy,
  input  logic [ADDR_W+DATA_W:0]  cmd_enq_v,
  output logic                    spi_req_ena,
  input  logic                    spi_req_rdy,
  output logic [WIDTH-1:0]        spi_req_v,
  input  logic                    spi_rsp_ena,
  output logic                    spi_rsp_rdy,
  input  logic [WIDTH-1:0]        spi_rsp_v,
  output logic                    rsp_enq_ena,
  input  logic                    rsp_enq_rdy,
  output logic [DATA_W+1:0]       rsp_enq_v,
  output logic                    cs_n,
  output logic                    busy
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int MAXC0 = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int MAXC  = (MAXC0 > TIMEOUT) ? MAXC0 : TIMEOUT;
  localparam int CNT_W = $clog2(MAXC + 1);

  generate
    if (WIDTH < CMD_W) begin : g_width_chk
      $error("spi_reg_sequencer: WIDTH too small for rw+addr+data");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_WAIT,
    S_REPLY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  frame_q, frame_d;
  logic [DATA_W+1:0] rsp_q, rsp_d;
  logic              rw_q, rw_d;
  logic              cs_n_q, cs_n_d;

  logic              cmd_rw;
  logic [DATA_W-1:0] cmd_wdata;
  logic [WIDTH-1:0]  frame_pk;
  logic [DATA_W-1:0] rx_data;
  logic              unused_rsp_bits;

  assign cmd_rw    = cmd_enq_v[CMD_W-1];
  // Reads never put write data on the wire.
  assign cmd_wdata = cmd_rw ? '0 : cmd_enq_v[DATA_W-1:0];
  assign rx_data   = spi_rsp_v[WIDTH-2-ADDR_W -: DATA_W];
  assign unused_rsp_bits = ^spi_rsp_v;

  // Frame is left-justified; any pad bits below the data stay zero.
  always_comb begin
    frame_pk = '0;
    frame_pk[WIDTH-1 -: CMD_W] =
      {cmd_rw, cmd_enq_v[CMD_W-2 -: ADDR_W], cmd_wdata};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    rsp_d       = rsp_q;
    rw_d        = rw_q;
    cmd_enq_rdy = 1'b0;
    spi_req_ena = 1'b0;
    rsp_enq_ena = 1'b0;
    spi_rsp_rdy = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cmd_enq_rdy = 1'b1;
        if (cmd_enq_ena) begin
          frame_d = frame_pk;
          rw_d    = cmd_rw;
          cnt_d   = CNT_W'(CS_SETUP - 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_SEND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SEND: begin
        spi_req_ena = spi_req_rdy;
        if (spi_req_rdy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the expiry cycle takes priority over the error.
        if (spi_rsp_ena) begin
          rsp_d   = {1'b0, rw_q, rx_data};
          state_d = S_REPLY;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_d   = {1'b1, rw_q, {DATA_W{1'b0}}};
          state_d = S_REPLY;
        end
      end
      S_REPLY: begin
        spi_rsp_rdy = 1'b0;
        rsp_enq_ena = rsp_enq_rdy;
        if (rsp_enq_rdy) begin
          cnt_d   = CNT_W'(CS_GAP - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cs_n is registered from the next state so it is low exactly in
  // SETUP, SEND and WAIT.
  assign cs_n_d = !(state_d == S_SETUP || state_d == S_SEND ||
                    state_d == S_WAIT);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      rsp_q   <= '0;
      rw_q    <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      rsp_q   <= rsp_d;
      rw_q    <= rw_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign spi_req_v = frame_q;
  assign rsp_enq_v = rsp_q;
  assign cs_n      = cs_n_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Scoreboard bench for spi_reg_sequencer: directed commands, a simple
// shift-engine model, and a monitor checking frames and replies.
module tb_spi_reg_sequencer;

  logic        CLK;
  logic        nRST;
  logic        cmd_enq_ena;
  logic        cmd_enq_rdy;
  logic [23:0] cmd_enq_v;
  logic        spi_req_ena;
  logic        spi_req_rdy;
  logic [25:0] spi_req_v;
  logic        spi_rsp_ena;
  logic        spi_rsp_rdy;
  logic [25:0] spi_rsp_v;
  logic        rsp_enq_ena;
  logic        rsp_enq_rdy;
  logic [17:0] rsp_enq_v;
  logic        cs_n;
  logic        busy;

  spi_reg_sequencer dut (
    .CLK(CLK),
    .nRST(nRST),
    .cmd_enq_ena(cmd_enq_ena),
    .cmd_enq_rdy(cmd_enq_rdy),
    .cmd_enq_v(cmd_enq_v),
    .spi_req_ena(spi_req_ena),
    .spi_req_rdy(spi_req_rdy),
    .spi_req_v(spi_req_v),
    .spi_rsp_ena(spi_rsp_ena),
    .spi_rsp_rdy(spi_rsp_rdy),
    .spi_rsp_v(spi_rsp_v),
    .rsp_enq_ena(rsp_enq_ena),
    .rsp_enq_rdy(rsp_enq_rdy),
    .rsp_enq_v(rsp_enq_v),
    .cs_n(cs_n),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int n_req  = 0;
  int n_rsp  = 0;

  logic [25:0] exp_req[$];
  logic [17:0] exp_rsp[$];

  logic [25:0] eng_frame = '0;
  int          eng_lat   = 1;
  logic        eng_drop  = 1'b0;
  int          late_cnt  = 0;
  int          late_done = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every transfer on a DUT output pops the scoreboard.
  always @(negedge CLK) begin
    if (nRST) begin
      if (spi_req_ena) begin
        n_req++;
        if (exp_req.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spi_req_unexpected: got %h", spi_req_v);
        end else begin
          chk("spi_req_v", 32'(spi_req_v), 32'(exp_req.pop_front()));
        end
      end
      if (rsp_enq_ena) begin
        n_rsp++;
        if (exp_rsp.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got %h", rsp_enq_v);
        end else begin
          chk("rsp_enq_v", 32'(rsp_enq_v), 32'(exp_rsp.pop_front()));
        end
      end
    end
  end

  // Shift-engine model: answers each frame eng_lat edges later,
  // or sends an unsolicited late frame on request.
  initial begin
    spi_rsp_ena = 1'b0;
    spi_rsp_v   = '0;
    forever begin
      @(negedge CLK);
      if (nRST && spi_req_ena && !eng_drop) begin
        repeat (eng_lat) @(posedge CLK);
        #1;
        spi_rsp_ena = 1'b1;
        spi_rsp_v   = eng_frame;
        @(posedge CLK);
        #1;
        spi_rsp_ena = 1'b0;
        spi_rsp_v   = '0;
      end else if (late_cnt != late_done) begin
        late_done++;
        @(posedge CLK);
        #1;
        spi_rsp_ena = 1'b1;
        spi_rsp_v   = eng_frame;
        @(posedge CLK);
        #1;
        spi_rsp_ena = 1'b0;
        spi_rsp_v   = '0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [23:0] c, output int waited);
    waited = 0;
    while (!cmd_enq_rdy && waited < 500) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    if (!cmd_enq_rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: cmd %h never accepted", c);
    end else begin
      cmd_enq_v   = c;
      cmd_enq_ena = 1'b1;
      @(posedge CLK);
      #1;
      cmd_enq_ena = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!rsp_enq_ena && n < 300);
    if (!rsp_enq_ena) begin
      n_chk++;
      n_fail++;
      $display("FAIL reply_timeout: no reply after %0d cycles", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    nRST        = 1'b0;
    cmd_enq_ena = 1'b0;
    cmd_enq_v   = '0;
    spi_req_rdy = 1'b1;
    rsp_enq_rdy = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ena", 32'(spi_req_ena), 0);
    chk("rst_rsp_ena", 32'(rsp_enq_ena), 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    chk("idle_rdy", 32'(cmd_enq_rdy), 1);
    @(posedge CLK);
    #1;

    // Write: frame 2 cycles after accept, any rdata echoed back.
    eng_frame = 26'h3FFFFFF;
    exp_req.push_back(26'h056FBBC);
    exp_rsp.push_back(18'h0FFFF);
    issue({1'b0, 7'h15, 16'hBEEF}, t);
    @(negedge CLK);
    chk("setup_cs_n", 32'(cs_n), 0);
    chk("setup_req_ena", 32'(spi_req_ena), 0);
    @(negedge CLK);
    chk("send_req_ena", 32'(spi_req_ena), 1);
    chk("send_cs_n", 32'(cs_n), 0);
    wait_rsp(n);
    @(negedge CLK);
    chk("gap1_cs_n", 32'(cs_n), 1);
    chk("gap1_rdy", 32'(cmd_enq_rdy), 0);
    @(negedge CLK);
    chk("gap2_cs_n", 32'(cs_n), 1);
    chk("gap2_rdy", 32'(cmd_enq_rdy), 0);
    @(negedge CLK);
    chk("gap_done_rdy", 32'(cmd_enq_rdy), 1);
    @(posedge CLK);
    #1;

    // Read: wdata field zeroed, rdata extracted.
    eng_frame = 26'h00048D0;
    exp_req.push_back(26'h2540000);
    exp_rsp.push_back(18'h11234);
    issue({1'b1, 7'h15, 16'hAAAA}, t);
    wait_rsp(n);
    @(posedge CLK);
    #1;

    // Back-to-back: spacing between accepts is 7 edges here.
    eng_frame = 26'h0000004;
    exp_req.push_back(26'h00C03FC);
    exp_req.push_back(26'h2100000);
    exp_rsp.push_back(18'h00001);
    exp_rsp.push_back(18'h10001);
    issue({1'b0, 7'h03, 16'h00FF}, t);
    issue({1'b1, 7'h04, 16'hFFFF}, t);
    chk("b2b_spacing", 32'(t + 1), 7);
    wait_rsp(n);
    @(posedge CLK);
    #1;

    // Timeout: 64 WAIT cycles, error reply, late frame swallowed.
    eng_drop  = 1'b1;
    eng_frame = 26'h3FFFFFF;
    exp_req.push_back(26'h2A80000);
    exp_rsp.push_back(18'h30000);
    issue({1'b1, 7'h2A, 16'h1357}, t);
    wait_rsp(n);
    chk("timeout_latency", 32'(n), 67);
    late_cnt++;
    @(negedge CLK);
    chk("late_rsp_rdy1", 32'(spi_rsp_rdy), 1);
    chk("late_cs_n", 32'(cs_n), 1);
    @(negedge CLK);
    chk("late_rsp_rdy2", 32'(spi_rsp_rdy), 1);
    @(negedge CLK);
    chk("late_idle", 32'(cmd_enq_rdy), 1);
    repeat (3) @(negedge CLK);
    eng_drop = 1'b0;
    @(posedge CLK);
    #1;

    // Host stall in REPLY: reply held, nothing else moves.
    rsp_enq_rdy = 1'b0;
    eng_frame   = 26'h1555555;
    exp_req.push_back(26'h0040108);
    exp_rsp.push_back(18'h05555);
    issue({1'b0, 7'h01, 16'h0042}, t);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(busy && !spi_rsp_rdy) && n < 200);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge CLK);
      chk("stall_v", 32'(rsp_enq_v), 32'h05555);
      chk("stall_ena", 32'(rsp_enq_ena), 0);
      chk("stall_spi_rdy", 32'(spi_rsp_rdy), 0);
      chk("stall_cmd_rdy", 32'(cmd_enq_rdy), 0);
    end
    @(posedge CLK);
    #1 rsp_enq_rdy = 1'b1;
    wait_rsp(n);
    @(negedge CLK);
    chk("stall_single_xfer", 32'(rsp_enq_ena), 0);
    @(posedge CLK);
    #1;

    // Reset in WAIT: no reply, then a clean command.
    eng_drop = 1'b1;
    exp_req.push_back(26'h2400000);
    issue({1'b1, 7'h10, 16'h0000}, t);
    repeat (6) @(posedge CLK);
    #1 nRST = 1'b0;
    @(negedge CLK);
    chk("pre_rst_cs_n", 32'(cs_n), 0);
    @(negedge CLK);
    chk("mid_rst_cs_n", 32'(cs_n), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rsp_ena", 32'(rsp_enq_ena), 0);
    chk("mid_rst_req_ena", 32'(spi_req_ena), 0);
    @(posedge CLK);
    #1;
    nRST     = 1'b1;
    eng_drop = 1'b0;
    eng_frame = 26'h2AAAAAA;
    exp_req.push_back(26'h1FC48D0);
    exp_rsp.push_back(18'h0AAAA);
    issue({1'b0, 7'h7F, 16'h1234}, t);
    wait_rsp(n);
    repeat (5) @(negedge CLK);

    chk("req_queue_empty", 32'(exp_req.size()), 0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    chk("frame_count", 32'(n_req), 8);
    chk("reply_count", 32'(n_rsp), 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
